fc_event_queue: RTL and testbench

// - Collects event IDs from NB_SRC peripheral/HWPE sources and serialises them into one ordered event stream.
// - Arbitration is round-robin. Events are buffered in a FIFO.
// - Sits directly upstream of the FC subsystem event input and drives event_fifo_valid/data.
// - Consumes the subsystem's event_fifo_fulln flow control.

---
 rtl/fc_event_queue.sv | 151 +++++++++++++++
 tb/tb_fc_event_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_event_queue.sv
// fc_event_queue: round-robin collector that serialises event IDs from NB_SRC
// sources into one ordered FIFO stream towards the FC subsystem event input.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   src_valid_i/id_i    per-source event request and ID (slice n*W +: W)
//   src_ready_o         one-hot accept strobe for the granted source (comb)
//   event_fifo_valid_o  head entry valid (FIFO not empty)
//   event_fifo_data_o   head event ID, read from the registered FIFO array
//   event_fifo_fulln_i  downstream ready; pop = valid & fulln
//   level_o             FIFO occupancy
//   drop_cnt_o          saturating discarded-event count (drop mode only)
//
// Build option: define FC_EVENT_QUEUE_DROP_EN for drop mode, where a granted
// source is always accepted and events arriving while full are discarded.
// Default build applies back-pressure instead.
module fc_event_queue #(
  parameter int unsigned NB_SRC         = 4,
  parameter int unsigned EVENT_ID_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NB_SRC-1:0]                src_valid_i,
  input  logic [NB_SRC*EVENT_ID_WIDTH-1:0] src_id_i,
  output logic [NB_SRC-1:0]                src_ready_o,
  output logic                             event_fifo_valid_o,
  output logic [EVENT_ID_WIDTH-1:0]        event_fifo_data_o,
  input  logic                             event_fifo_fulln_i,
`ifdef FC_EVENT_QUEUE_DROP_EN
  output logic [15:0]                      drop_cnt_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]      level_o
);

  localparam int unsigned SW = $clog2(NB_SRC);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [SW-1:0]             rr_q;
  logic [PW-1:0]             rd_ptr_q;
  logic [PW-1:0]             wr_ptr_q;
  logic [LW-1:0]             level_q;
  logic [EVENT_ID_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [EVENT_ID_WIDTH-1:0] src_ids [NB_SRC];
  logic [EVENT_ID_WIDTH-1:0] grant_id;
  logic [SW-1:0]             grant_idx;
  logic [SW-1:0]             next_rr;
  logic [SW:0]               scan;
  logic [NB_SRC-1:0]         grant_oh;
  logic                      any_grant;
  logic                      pop;
  logic                      full;
  logic                      can_push;
  logic                      push;
  logic                      accept;

  // Unpack the flat ID bus so the granted ID can be selected by index.
  for (genvar n = 0; n < NB_SRC; n++) begin : g_ids
    assign src_ids[n] = src_id_i[n*EVENT_ID_WIDTH +: EVENT_ID_WIDTH];
  end

  // Round-robin scan: first valid source at or after rr_q, wrapping upward.
  always_comb begin
    any_grant = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int unsigned k = 0; k < NB_SRC; k++) begin
      scan = {1'b0, rr_q} + (SW+1)'(k);
      if (scan >= (SW+1)'(NB_SRC)) begin
        scan = scan - (SW+1)'(NB_SRC);
      end
      if (!any_grant && src_valid_i[scan[SW-1:0]]) begin
        any_grant = 1'b1;
        grant_idx = scan[SW-1:0];
      end
    end
  end

  assign grant_oh = any_grant ? (NB_SRC'(1) << grant_idx) : '0;
  assign grant_id = src_ids[grant_idx];
  assign next_rr  = (grant_idx == SW'(NB_SRC - 1)) ? '0 : grant_idx + 1'b1;

  assign event_fifo_valid_o = (level_q != '0);
  assign event_fifo_data_o  = event_fifo_valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o            = level_q;

  assign pop      = event_fifo_valid_o & event_fifo_fulln_i;
  assign full     = (level_q == LW'(FIFO_DEPTH));
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign can_push = ~full | pop;
  assign push     = any_grant & can_push;

`ifdef FC_EVENT_QUEUE_DROP_EN
  logic        drop;
  logic [15:0] drop_cnt_q;

  // Granted source always completes; the event is lost if there is no room.
  assign src_ready_o = grant_oh;
  assign drop        = any_grant & ~can_push;
  assign drop_cnt_o  = drop_cnt_q;

  // Saturating discard counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
`else
  // Back-pressure: no source is accepted while there is no room.
  assign src_ready_o = can_push ? grant_oh : '0;
`endif

  assign accept = |src_ready_o;

  // Arbiter pointer, FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (accept) begin
        rr_q <= next_rr;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array; contents need no reset since level_q qualifies them.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_q[wr_ptr_q] <= grant_id;
    end
  end

endmodule

// File: tb/tb_fc_event_queue.sv
// Randomised scoreboard bench for fc_event_queue: a queue-based reference
// model predicts grants, occupancy and delivered event order.
module tb_fc_event_queue;

  localparam int NB_SRC = 4;
  localparam int W      = 8;
  localparam int DEPTH  = 8;
  localparam int LW     = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NB_SRC-1:0]     src_valid;
  logic [NB_SRC*W-1:0]   src_id;
  logic [NB_SRC-1:0]     src_ready;
  logic                  ev_valid;
  logic [W-1:0]          ev_data;
  logic                  fulln;
  logic [LW-1:0]         level;
`ifdef FC_EVENT_QUEUE_DROP_EN
  logic [15:0]           drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [W-1:0] exp_q[$];
  int           rr;
  int           mlevel;
  int           mdrop;
  bit           pend_v [NB_SRC];
  logic [W-1:0] pend_id[NB_SRC];
  bit           after_reset;
  int           p_valid;
  int           p_fulln;
  bit           fixed_ids;

  fc_event_queue #(
    .NB_SRC(NB_SRC), .EVENT_ID_WIDTH(W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .src_valid_i        (src_valid),
    .src_id_i           (src_id),
    .src_ready_o        (src_ready),
    .event_fifo_valid_o (ev_valid),
    .event_fifo_data_o  (ev_data),
    .event_fifo_fulln_i (fulln),
`ifdef FC_EVENT_QUEUE_DROP_EN
    .drop_cnt_o         (drop_cnt),
`endif
    .level_o            (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the presented head against the oldest expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head_data actual=%0h required=<none> t=%0t", ev_data, $time);
        end else begin
          check("head_data", 32'(ev_data), 32'(exp_q[0]));
          if (fulln) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Present pending events; new ones appear only on idle sources.
  task automatic drive();
    for (int n = 0; n < NB_SRC; n++) begin
      if (!pend_v[n] && ($urandom_range(0, 99) < p_valid)) begin
        pend_v[n]  = 1'b1;
        pend_id[n] = fixed_ids ? 8'(32'hA0 + n) : 8'($urandom);
      end
      src_valid[n]       = pend_v[n];
      src_id[n*W +: W]   = pend_id[n];
    end
    fulln = ($urandom_range(0, 99) < p_fulln);
  endtask

  // Reference model for one clock cycle, evaluated mid-cycle.
  task automatic model_cycle();
    bit                pop;
    bit                room;
    bit                acc;
    bit                psh;
    int                g;
    logic [NB_SRC-1:0] exp_rdy;
    pop = (mlevel != 0) && fulln;
    g = -1;
    for (int k = 0; k < NB_SRC; k++) begin
      int n;
      n = (rr + k) % NB_SRC;
      if (g < 0 && pend_v[n]) g = n;
    end
    room = (mlevel < DEPTH) || pop;
`ifdef FC_EVENT_QUEUE_DROP_EN
    acc = (g >= 0);
`else
    acc = (g >= 0) && room;
`endif
    psh = acc && room;
    exp_rdy = '0;
    if (acc) exp_rdy[g] = 1'b1;
    check("src_ready", 32'(src_ready), 32'(exp_rdy));
    check("level", 32'(level), 32'(mlevel));
    check("valid", 32'(ev_valid), 32'(mlevel != 0));
    if (after_reset) check("reset_data", 32'(ev_data), 32'(0));
    after_reset = 1'b0;
`ifdef FC_EVENT_QUEUE_DROP_EN
    check("drop_cnt", 32'(drop_cnt), 32'(mdrop));
    if (acc && !room && mdrop < 65535) mdrop++;
`endif
    if (psh) exp_q.push_back(pend_id[g]);
    if (acc) begin
      pend_v[g] = 1'b0;
      rr = (g + 1) % NB_SRC;
    end
    mlevel = mlevel + int'(psh) - int'(pop);
  endtask

  task automatic run(input int cycles, input int pv, input int pf, input bit fixed);
    p_valid   = pv;
    p_fulln   = pf;
    fixed_ids = fixed;
    repeat (cycles) begin
      drive();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    src_valid = '0;
    fulln     = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mlevel = 0;
    rr     = 0;
    mdrop  = 0;
    for (int n = 0; n < NB_SRC; n++) pend_v[n] = 1'b0;
    after_reset = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    src_valid = '0;
    src_id    = '0;
    fulln     = 1'b0;
    for (int n = 0; n < NB_SRC; n++) begin
      pend_v[n]  = 1'b0;
      pend_id[n] = '0;
    end
    do_reset(2);

    // Single event from source 0 into an empty FIFO.
    pend_v[0]  = 1'b1;
    pend_id[0] = 8'h11;
    run(4, 0, 100, 1'b0);

    // All sources constantly valid with fixed IDs: round-robin order.
    run(40, 100, 100, 1'b1);
    run(10, 0, 100, 1'b0);

    // Downstream stalled: fill to full, then sustained back-pressure.
    run(20, 100, 0, 1'b0);
    check("full_level", 32'(level), 32'(DEPTH));

    // Full with pop and push in the same cycle.
    run(40, 100, 100, 1'b0);

    // Mixed random traffic.
    run(200, 50, 60, 1'b0);

    // Reset with a partially filled FIFO, then arbitration restarts at 0.
    run(12, 0, 100, 1'b0);
    run(5, 100, 0, 1'b0);
    check("level_before_reset", 32'(level), 32'(5));
    do_reset(1);
    run(30, 70, 50, 1'b0);

    // Heavy random traffic with frequent stalls.
    run(300, 70, 40, 1'b0);

    // Drain and confirm nothing was lost.
    run(20, 0, 100, 1'b0);
    check("drained", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
